// File: rtl/spi_reg_pkg.sv
// Shared types, constants and the SPI word packing helper for the register-access sequencer.
package spi_reg_pkg;

   localparam int SPI_WORD_W  = 32;
   localparam int SPI_RNW_BIT = 31;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_RESP,
      ST_GAP
   } spi_seq_state_t;

   // Callers zero-extend addr/wdata to the word width, so unused bits stay 0.
   function automatic logic [SPI_WORD_W-1:0] spi_pack_word(
      input logic                  rnw,
      input logic [SPI_WORD_W-1:0] addr,
      input logic [SPI_WORD_W-1:0] wdata,
      input int                    data_w = 8
   );
      logic [SPI_WORD_W-1:0] word;
      word = addr << data_w;
      if (!rnw) begin
         word = word | wdata;
      end
      word[SPI_RNW_BIT] = rnw;
      return word;
   endfunction

endpackage

// File: rtl/spi_reg_seq_wdog.sv
// spi_busy watchdog for spi_reg_seq; only compiled when SPI_REG_SEQ_TIMEOUT_EN is defined.
`ifdef SPI_REG_SEQ_TIMEOUT_EN
module spi_reg_seq_wdog #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic clr,
   input  logic run,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt;

   // The clearing cycle itself counts, so the error response lands TIMEOUT_CYC cycles after ISSUE.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= CNT_W'(1);
      end else if (run && !expired) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired = run && (cnt >= CNT_W'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/spi_reg_seq.sv
// Register read/write sequencer driving spi_master; one outstanding transaction at a time.
// Optional spi_busy watchdog enabled by defining SPI_REG_SEQ_TIMEOUT_EN.
module spi_reg_seq
   import spi_reg_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int CS_GAP_CYC  = 8,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_rnw,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  spi_wr_cmd,
   output logic                  spi_rd_cmd,
   output logic [SPI_WORD_W-1:0] spi_wr_data,
   input  logic                  spi_busy,
   input  logic [DATA_W-1:0]     spi_rd_data,
   output logic                  seq_busy
);

   localparam int GAP_CNT_W = (CS_GAP_CYC > 1) ? $clog2(CS_GAP_CYC) : 1;
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((CS_GAP_CYC > 0) ? CS_GAP_CYC - 1 : 0);

   spi_seq_state_t       state;
   logic                 idle_rdy;
   logic [GAP_CNT_W-1:0] gap_cnt;
   logic                 expired;

`ifdef SPI_REG_SEQ_TIMEOUT_EN
   logic wdog_clr;
   logic wdog_run;

   assign wdog_clr = (state == ST_ISSUE);
   assign wdog_run = (state == ST_WAIT_HI) || (state == ST_WAIT_LO);

   spi_reg_seq_wdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_wdog (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clr     (wdog_clr),
      .run     (wdog_run),
      .expired (expired)
   );
`else
   assign expired = 1'b0;

   // TIMEOUT_CYC only matters with the watchdog; this empty block keeps it referenced.
   if (TIMEOUT_CYC < 2) begin : g_timeout_unused
   end
`endif

   // idle_rdy is registered so ready stays low during reset and rises one edge after release.
   assign req_ready = idle_rdy && !spi_busy;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= ST_IDLE;
         idle_rdy    <= 1'b0;
         seq_busy    <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         spi_wr_cmd  <= 1'b0;
         spi_rd_cmd  <= 1'b0;
         spi_wr_data <= '0;
         gap_cnt     <= '0;
      end else begin
         spi_wr_cmd <= 1'b0;
         spi_rd_cmd <= 1'b0;
         case (state)
            ST_IDLE: begin
               idle_rdy <= 1'b1;
               if (req_valid && req_ready) begin
                  state       <= ST_ISSUE;
                  idle_rdy    <= 1'b0;
                  seq_busy    <= 1'b1;
                  spi_wr_data <= spi_pack_word(req_rnw, SPI_WORD_W'(req_addr),
                                               SPI_WORD_W'(req_wdata), DATA_W);
                  spi_wr_cmd  <= !req_rnw;
                  spi_rd_cmd  <= req_rnw;
               end
            end
            ST_ISSUE: begin
               state <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (expired) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else if (spi_busy) begin
                  state <= ST_WAIT_LO;
               end
            end
            ST_WAIT_LO: begin
               // A frame that completes on the expiry cycle is still reported as good.
               if (!spi_busy) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= spi_wr_data[SPI_RNW_BIT] ? spi_rd_data : '0;
               end else if (expired) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  gap_cnt   <= '0;
                  if (CS_GAP_CYC == 0) begin
                     state    <= ST_IDLE;
                     seq_busy <= 1'b0;
                     idle_rdy <= 1'b1;
                  end else begin
                     state <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state    <= ST_IDLE;
                  seq_busy <= 1'b0;
                  idle_rdy <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + GAP_CNT_W'(1);
               end
            end
            default: begin
               state    <= ST_IDLE;
               seq_busy <= 1'b0;
               idle_rdy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_reg_seq.sv
// Self-checking bench for spi_reg_seq with a behavioural spi_master/register-file model.
module tb_spi_reg_seq;

   localparam int ADDR_W   = 16;
   localparam int DATA_W   = 8;
   localparam int CS_GAP   = 8;
   localparam int TIMEOUT  = 64;
   localparam int BUSY_LEN = 40;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_rnw = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              spi_wr_cmd;
   logic              spi_rd_cmd;
   logic [31:0]       spi_wr_data;
   logic              spi_busy;
   logic [DATA_W-1:0] spi_rd_data = '0;
   logic              seq_busy;

   int n_asserts = 0;
   int n_fail    = 0;
   int cyc       = 0;

   logic       slave_busy = 1'b0;
   logic       force_busy = 1'b0;
   logic       slave_mute = 1'b0;
   int         busy_left  = 0;
   logic [7:0] slave_mem [int];
   logic [7:0] ref_mem [int];

   spi_reg_seq #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .CS_GAP_CYC  (CS_GAP),
      .TIMEOUT_CYC (TIMEOUT)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_rnw     (req_rnw),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .spi_wr_cmd  (spi_wr_cmd),
      .spi_rd_cmd  (spi_rd_cmd),
      .spi_wr_data (spi_wr_data),
      .spi_busy    (spi_busy),
      .spi_rd_data (spi_rd_data),
      .seq_busy    (seq_busy)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // spi_master stand-in: a strobe starts a BUSY_LEN-cycle frame against a small register file.
   assign spi_busy = slave_busy | force_busy;

   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         slave_busy <= 1'b0;
         busy_left  <= 0;
      end else if (busy_left > 1) begin
         busy_left <= busy_left - 1;
      end else if (busy_left == 1) begin
         busy_left  <= 0;
         slave_busy <= 1'b0;
      end else if ((spi_wr_cmd || spi_rd_cmd) && !slave_mute) begin
         busy_left  <= BUSY_LEN;
         slave_busy <= 1'b1;
         if (spi_wr_data[31]) begin
            spi_rd_data <= slave_mem.exists(int'(spi_wr_data[23:8])) ?
                           slave_mem[int'(spi_wr_data[23:8])] : 8'h00;
         end else begin
            slave_mem[int'(spi_wr_data[23:8])] = spi_wr_data[7:0];
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: observed no end of test, expected finish");
      $fatal(1, "[TB] simulation time limit");
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Starts and ends on a falling edge; waits counts cycles spent with ready low.
   task automatic apply_stimulus(input logic rnw, input logic [15:0] addr, input logic [7:0] wdata,
                                 output int waits, output int issue_cyc);
      logic [31:0] exp_word;
      bit          done;
      exp_word  = (32'(rnw) << 31) | (32'(addr) << 8) | (rnw ? 32'h0 : 32'(wdata));
      req_valid = 1'b1;
      req_rnw   = rnw;
      req_addr  = addr;
      req_wdata = wdata;
      waits     = 0;
      issue_cyc = 0;
      done      = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         if (req_ready) done = 1'b1;
         else begin
            waits++;
            @(negedge sys_clk);
         end
      end
      check_output("accept_bound", 64'(done), 64'd1);
      @(negedge sys_clk);
      req_valid = 1'b0;
      req_wdata = 8'($urandom);
      req_addr  = 16'($urandom);
      issue_cyc = cyc;
      check_output("cmd_strobe", {spi_wr_cmd, spi_rd_cmd}, {!rnw, rnw});
      check_output("wr_data", spi_wr_data, exp_word);
      check_output("seq_busy_issue", seq_busy, 1'b1);
      @(negedge sys_clk);
      check_output("strobe_one_cycle", {spi_wr_cmd, spi_rd_cmd}, 2'b00);
      check_output("wr_data_held", spi_wr_data, exp_word);
   endtask

   task automatic get_rsp(input int hold, input logic [7:0] exp_data, input logic exp_err,
                          output int valid_cyc, output logic b1, output logic b2);
      bit found;
      int drops;
      found = 1'b0;
      b1 = 1'b0;
      b2 = 1'b0;
      valid_cyc = 0;
      for (int i = 0; i < 500 && !found; i++) begin
         if (rsp_valid) found = 1'b1;
         else begin
            b2 = b1;
            b1 = spi_busy;
            @(negedge sys_clk);
         end
      end
      check_output("rsp_bound", 64'(found), 64'd1);
      if (!found) return;
      valid_cyc = cyc;
      check_output("rsp_rdata", rsp_rdata, exp_data);
      check_output("rsp_err", rsp_err, exp_err);
      drops = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge sys_clk);
         if (!rsp_valid) drops++;
      end
      if (hold > 0) check_output("rsp_held", 64'(drops), 64'd0);
      rsp_ready = 1'b1;
      @(negedge sys_clk);
      rsp_ready = 1'b0;
      check_output("rsp_cleared", {rsp_valid, seq_busy}, {1'b0, (CS_GAP > 0) ? 1'b1 : 1'b0});
   endtask

   // Reference: expected read data comes from the bench's own record of writes.
   task automatic do_txn(input logic rnw, input logic [15:0] addr, input logic [7:0] wdata,
                         input int hold, output int waits);
      logic [7:0] exp_d;
      int         ic;
      int         vc;
      logic       b1;
      logic       b2;
      if (rnw) exp_d = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 8'h00;
      else begin
         ref_mem[int'(addr)] = wdata;
         exp_d = 8'h00;
      end
      apply_stimulus(rnw, addr, wdata, waits, ic);
      get_rsp(hold, exp_d, 1'b0, vc, b1, b2);
      check_output("rsp_after_busy_fall", {b2, b1}, 2'b10);
   endtask

   initial begin
      int   waits;
      int   ic;
      int   vc;
      int   bad;
      logic b1;
      logic b2;

      slave_mem[int'(16'h00CD)] = 8'h5A;
      ref_mem[int'(16'h00CD)]   = 8'h5A;

      repeat (3) @(negedge sys_clk);
      check_output("reset_outputs",
                   {req_ready, rsp_valid, rsp_rdata, rsp_err, spi_wr_cmd, spi_rd_cmd, spi_wr_data, seq_busy},
                   64'd0);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      check_output("ready_after_reset", req_ready, 1'b1);

      do_txn(1'b0, 16'h1234, 8'hA5, 0, waits);
      do_txn(1'b1, 16'h00CD, 8'h00, 0, waits);
      check_output("gap_wait_read", 64'(waits), 64'(CS_GAP));

      do_txn(1'b1, 16'h1234, 8'h00, 10, waits);
      do_txn(1'b0, 16'h1235, 8'h3C, 0, waits);
      check_output("gap_wait_after_hold", 64'(waits), 64'(CS_GAP));

      for (int i = 0; i < 12; i++) begin
         do_txn(1'($urandom), 16'(16'h1230 + $urandom_range(0, 7)), 8'($urandom),
                int'($urandom_range(0, 4)), waits);
         check_output("gap_wait_random", 64'(waits), 64'(CS_GAP));
      end

`ifdef SPI_REG_SEQ_TIMEOUT_EN
      slave_mute = 1'b1;
      apply_stimulus(1'b1, 16'h1231, 8'h00, waits, ic);
      get_rsp(0, 8'h00, 1'b1, vc, b1, b2);
      check_output("timeout_latency", 64'(vc - ic), 64'(TIMEOUT));
      slave_mute = 1'b0;
      do_txn(1'b1, 16'h00CD, 8'h00, 0, waits);
      check_output("gap_wait_after_timeout", 64'(waits), 64'(CS_GAP));
`endif

      // Foreign spi_master activity: ready must stay low and nothing may be issued.
      force_busy = 1'b1;
      req_valid  = 1'b1;
      req_rnw    = 1'b0;
      req_addr   = 16'h0042;
      req_wdata  = 8'h99;
      rsp_ready  = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge sys_clk);
         if (req_ready || spi_wr_cmd || spi_rd_cmd || rsp_valid) bad++;
      end
      check_output("foreign_busy_blocks", 64'(bad), 64'd0);
      req_valid  = 1'b0;
      rsp_ready  = 1'b0;
      force_busy = 1'b0;
      @(negedge sys_clk);
      do_txn(1'b0, 16'h0042, 8'h77, 2, waits);

      // Reset in the middle of a frame drops the transaction.
      apply_stimulus(1'b1, 16'h0042, 8'h00, waits, ic);
      repeat (10) @(negedge sys_clk);
      check_output("in_wait_lo", {spi_busy, seq_busy, rsp_valid}, 3'b110);
      sys_rst = 1'b1;
      #1;
      check_output("reset_mid_outputs",
                   {req_ready, rsp_valid, rsp_rdata, rsp_err, spi_wr_cmd, spi_rd_cmd, spi_wr_data, seq_busy},
                   64'd0);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      check_output("ready_after_mid_reset", req_ready, 1'b1);
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge sys_clk);
         if (rsp_valid) bad++;
      end
      check_output("no_rsp_after_reset", 64'(bad), 64'd0);
      do_txn(1'b1, 16'h0042, 8'h00, 1, waits);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_reg_seq.md
# spi_reg_seq

Register-access sequencer that sits directly upstream of `spi_master` (instantiated with `MOSI_DATA_WIDTH=32`, `MISO_DATA_WIDTH=8`). It accepts single register read/write requests on a valid/ready interface and packs each into a 32-bit SPI word. It then drives the one-cycle `spi_wr_cmd`/`spi_rd_cmd` strobes, tracks `spi_busy` through the full frame, and returns one response (read data plus error flag) per request.

## Interface
Parameters:
- `ADDR_W`, 16, register address width; `ADDR_W + DATA_W + 1 <= 32`.
- `DATA_W`, 8, register data width; must equal the `spi_master` MISO width.
- `CS_GAP_CYC`, 8, minimum idle `sys_clk` cycles after a frame before the next request is accepted; 0 is legal.
- `TIMEOUT_CYC`, 4096, `spi_busy` watchdog limit in `sys_clk` cycles; used only with the macro.

Ports:
- `sys_clk` in 1: single clock; `spi_master` runs on the same clock.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_rnw` in 1: 1 = read, 0 = write.
- `req_addr` in ADDR_W: register address.
- `req_wdata` in DATA_W: write data; ignored for reads.
- `rsp_valid` out 1: response valid; held until `rsp_ready`.
- `rsp_ready` in 1: response accepted.
- `rsp_rdata` out DATA_W: read data; 0 for writes and errors.
- `rsp_err` out 1: transaction timed out.
- `spi_wr_cmd` out 1: one-cycle write strobe to `spi_master`.
- `spi_rd_cmd` out 1: one-cycle read strobe to `spi_master`.
- `spi_wr_data` out 32: packed MOSI word.
- `spi_busy` in 1: `spi_master` busy.
- `spi_rd_data` in DATA_W: `spi_master` MISO data.
- `seq_busy` out 1: high in every state except IDLE.

## Operation
- Word packing:
  - bit 31 = `rnw`.
  - `[DATA_W +: ADDR_W]` = addr.
  - `[DATA_W-1:0]` = wdata for writes, 0 for reads.
  - All other bits 0.
- The packed word is registered at acceptance and held stable until the next acceptance.
- FSM states:
  - IDLE: `req_ready = ~spi_busy`. On accept → ISSUE.
  - ISSUE: assert exactly one of `spi_wr_cmd`/`spi_rd_cmd` for one cycle → WAIT_HI.
  - WAIT_HI: wait for `spi_busy == 1` → WAIT_LO.
  - WAIT_LO: wait for `spi_busy == 0`. Capture `spi_rd_data` into `rsp_rdata` (reads only) → RESP.
  - RESP: `rsp_valid = 1` until `rsp_ready` → GAP.
  - GAP: count `CS_GAP_CYC` cycles → IDLE. With `CS_GAP_CYC = 0`, GAP lasts zero cycles (RESP → IDLE directly).
- Every request, read or write, yields exactly one response, in request order (one outstanding transaction).
- If `spi_busy` is already high in IDLE (foreign activity), no request is accepted.
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `spi_wr_cmd=0`, `spi_rd_cmd=0`, `spi_wr_data=0`, `seq_busy=0`; state = IDLE.
- `req_ready` may rise on the first cycle after reset deassertion.
- Reset mid-operation: everything returns to reset values on the same edge and the in-flight transaction is dropped with no response. `spi_master` shares `sys_rst`.

## Timing
- Accept at cycle N: command strobe high in cycle N+1 only; `spi_wr_data` valid from N+1.
- `spi_busy` seen low at cycle M in WAIT_LO: `rsp_valid` high from M+1.
- `rsp_valid` and the `rsp_ready` handshake: the response clears on the handshake edge. The GAP count then starts; `req_ready` rises `CS_GAP_CYC` cycles after RESP exits.
- Back-to-back minimum request period: 4 + `CS_GAP_CYC` + `spi_master` frame length.
- `rsp_ready` high while `rsp_valid` is low has no effect.
- `req_valid` is not required to stay high when `req_ready` is low. Requests are not dropped silently: ready is simply low.

## Configuration
- `SPI_REG_SEQ_TIMEOUT_EN` defined:
  - A cycle counter clears at ISSUE and runs through WAIT_HI and WAIT_LO.
  - When it reaches `TIMEOUT_CYC`, the FSM goes to RESP with `rsp_err=1` and `rsp_rdata=0`.
  - Either wait state can time out.
- Not defined: no counter; waits are unbounded; `rsp_err` is constant 0.

## Structure
- Shared package `spi_reg_pkg` holds:
  - the state enum `spi_seq_state_t`;
  - the `SPI_WORD_W = 32` and `SPI_RNW_BIT = 31` constants;
  - a packing function `spi_pack_word(rnw, addr, wdata)`.
- Sub-module `spi_reg_seq_wdog`: the timeout counter, present only under the macro. Its inputs are `clr` and `run`; its output is `expired`.

## Test plan
- Write 0x1234/0xA5 with a model `spi_master` (busy 40 cycles):
  - `spi_wr_data = 0x00123 4A5` → `0x001234A5`;
  - one-cycle `spi_wr_cmd` at N+1;
  - response with `rdata = 0`, `err = 0`.
- Read 0x00CD; the model returns 0x5A:
  - `spi_rd_cmd` strobe;
  - `spi_wr_data = 0x8000CD00`;
  - `rsp_rdata = 0x5A`, `rsp_valid` the cycle after busy falls.
- Two back-to-back requests with `rsp_ready` held low for 10 cycles on the first:
  - the second is not accepted until the first handshake completes plus 8 GAP cycles;
  - responses arrive in order.
- Macro on, `TIMEOUT_CYC = 64`, `spi_busy` never rises:
  - `rsp_err = 1` and `rsp_rdata = 0` at 64 cycles after ISSUE;
  - the next request then completes normally.
- `sys_rst` pulsed while in WAIT_LO:
  - all outputs are 0 immediately;
  - no response is emitted;
  - `req_ready` is high the cycle after release.
- `spi_busy` forced high while in IDLE with `req_valid` asserted:
  - `req_ready` stays 0 and no command strobe is issued.
